mux_rr_sched32: RTL

- Round-robin scheduler that shares one 32:1 bit-select datapath between 32 requesters.
- Produces the 5-bit select that drives the mux tree, plus a one-hot grant returned to the requesters.
- Holds each grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits between requester logic and the 32:1 select mux; owns all sequencing of that select.

---
 rtl/mux_rr_sched32.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mux_rr_sched32.sv
// mux_rr_sched32 -- round-robin owner scheduler for a shared 32:1 bit-select mux.
//
// Picks one of 32 requesters and holds the grant until the owner signals done,
// drops its request, or hits the hold limit. Hand-off to the next requester in
// round-robin order happens with no idle cycle in between.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   req[31:0]   request vector, bit i = requester i wants the mux
//   done        current owner finished (only looked at while a grant is active)
//   gnt_valid   a grant is active this cycle
//   gnt_sel     index of the owner, drives the mux select
//   gnt_onehot  one-hot of gnt_sel while gnt_valid=1, else 0
//   timeout     one-cycle pulse: previous owner was force-released by the hold limit
//
// Parameters:
//   MAX_HOLD    max consecutive grant cycles per owner, 0 = unlimited
//   HOLD_W      hold counter width, MAX_HOLD must be < 2**HOLD_W
module mux_rr_sched32 #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] req,
  input  logic        done,
  output logic        gnt_valid,
  output logic [4:0]  gnt_sel,
  output logic [31:0] gnt_onehot,
  output logic        timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state_q, state_d;
  logic [4:0]        ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [4:0]        gnt_sel_q, gnt_sel_d;
  logic [31:0]       gnt_onehot_q, gnt_onehot_d;
  logic              timeout_q, timeout_d;

  // Round-robin search
  logic [31:0] cand;
  logic        found;
  logic [4:0]  winner;
  logic [4:0]  idx;

  // While granting, the current owner is masked so a release always moves on.
  always_comb begin
    cand   = (state_q == GRANT) ? (req & ~gnt_onehot_q) : req;
    found  = 1'b0;
    winner = 5'd0;
    idx    = 5'd0;
    // Scan from the farthest position back to the nearest so the nearest
    // candidate after ptr is the one left standing.
    for (int k = 31; k >= 0; k--) begin
      idx = ptr_q + 5'd1 + 5'(k);
      if (cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Release conditions
  logic owner_req;
  logic limit_hit;
  logic release_now;

  always_comb begin
    owner_req   = req[gnt_sel_q];
    limit_hit   = HOLD_EN && (hold_cnt_q == HOLD_LAST);
    release_now = done || !owner_req || limit_hit;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 5'd31;
      hold_cnt_q   <= '0;
      gnt_valid_q  <= 1'b0;
      gnt_sel_q    <= 5'd0;
      gnt_onehot_q <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_sel_q    <= gnt_sel_d;
      gnt_onehot_q <= gnt_onehot_d;
      timeout_q    <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = GRANT;
      GRANT:   if (release_now && !found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output logic
  always_comb begin
    ptr_d        = ptr_q;
    hold_cnt_d   = hold_cnt_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_sel_d    = gnt_sel_q;
    gnt_onehot_d = gnt_onehot_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_valid_d  = 1'b1;
          gnt_sel_d    = winner;
          gnt_onehot_d = 32'd1 << winner;
          ptr_d        = winner;
          hold_cnt_d   = '0;
        end else begin
          gnt_valid_d  = 1'b0;
          gnt_onehot_d = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          // A limit release coinciding with done or a dropped request is a
          // normal release and does not pulse timeout.
          timeout_d  = limit_hit && !done && owner_req;
          hold_cnt_d = '0;
          if (found) begin
            gnt_valid_d  = 1'b1;
            gnt_sel_d    = winner;
            gnt_onehot_d = 32'd1 << winner;
            ptr_d        = winner;
          end else begin
            gnt_valid_d  = 1'b0;
            gnt_onehot_d = '0;
          end
        end else if (hold_cnt_q != {HOLD_W{1'b1}}) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_valid_d  = 1'b0;
        gnt_onehot_d = '0;
      end
    endcase
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_sel    = gnt_sel_q;
  assign gnt_onehot = gnt_onehot_q;
  assign timeout    = timeout_q;

endmodule
